// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned ADDR_W  = 32;
  localparam logic [ADDR_W-1:0] PC_STEP = 32'd4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    WAIT  = 2'd2,
    DRAIN = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/if_id_slot.sv
// Single-entry valid/ready register between fetch and decode.
module if_id_slot
  import fetch_pkg::*;
(
  input  logic               clk,
  input  logic               rstn,
  input  logic               i_capture,
  input  logic [INSTR_W-1:0] i_instr,
  input  logic [ADDR_W-1:0]  i_pc,
  input  logic               i_consume,
  input  logic               i_flush,
  output logic               o_valid,
  output logic [INSTR_W-1:0] o_instr,
  output logic [ADDR_W-1:0]  o_pc,
  output logic [ADDR_W-1:0]  o_pc_plus4
);

  logic               r_valid;
  logic [INSTR_W-1:0] r_instr;
  logic [ADDR_W-1:0]  r_pc;
  logic [ADDR_W-1:0]  r_pc_plus4;

  // Flush wins over capture; a consume in the flush cycle is still a valid handoff.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_valid    <= 1'b0;
      r_instr    <= '0;
      r_pc       <= '0;
      r_pc_plus4 <= '0;
    end else if (i_flush) begin
      r_valid <= 1'b0;
    end else if (i_capture) begin
      r_valid    <= 1'b1;
      r_instr    <= i_instr;
      r_pc       <= i_pc;
      r_pc_plus4 <= i_pc + PC_STEP;
    end else if (i_consume) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid    = r_valid;
  assign o_instr    = r_instr;
  assign o_pc       = r_pc;
  assign o_pc_plus4 = r_pc_plus4;

endmodule

// File: rtl/instr_fetch.sv
// MIPS fetch stage: PC, imem request FSM, redirect handling, IF/ID slot.
module instr_fetch
  import fetch_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               rstn,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               if_valid,
  input  logic               if_ready,
  output logic [INSTR_W-1:0] if_instr,
  output logic [5:0]         if_opcode,
  output logic [ADDR_W-1:0]  if_pc,
  output logic [ADDR_W-1:0]  if_pc_plus4
);

  fetch_state_t      r_state;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_redir_pc;

  logic              w_req;
  logic              w_ack;
  logic              w_capture;
  logic              w_consume;
  logic [ADDR_W-1:0] w_target;
  logic [ADDR_W-1:0] w_pc_inc;

  always_comb begin
    w_req = 1'b0;
    unique case (r_state)
      IDLE:        w_req = 1'b0;
      FETCH:       w_req = !if_valid | if_ready;
      WAIT, DRAIN: w_req = 1'b1;
      default:     w_req = 1'b0;
    endcase
  end

  assign w_ack     = w_req & imem_ack;
  assign w_capture = w_ack & ((r_state == FETCH) | (r_state == WAIT)) & !redirect;
  assign w_consume = if_valid & if_ready;
  assign w_target  = redirect_pc & ~32'd3;
  assign w_pc_inc  = r_pc + PC_STEP;

  assign imem_req  = w_req;
  assign imem_addr = r_pc;

  // An un-acked request pins imem_addr, so a redirect must wait in DRAIN.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state    <= IDLE;
      r_pc       <= RESET_PC;
      r_redir_pc <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          r_state <= FETCH;
          if (redirect) r_pc <= w_target;
        end
        FETCH: begin
          if (w_req && !imem_ack) begin
            r_state <= redirect ? DRAIN : WAIT;
            if (redirect) r_redir_pc <= w_target;
          end else begin
            r_state <= FETCH;
            if (redirect)   r_pc <= w_target;
            else if (w_ack) r_pc <= w_pc_inc;
          end
        end
        WAIT: begin
          if (imem_ack) begin
            r_state <= FETCH;
            r_pc    <= redirect ? w_target : w_pc_inc;
          end else if (redirect) begin
            r_state    <= DRAIN;
            r_redir_pc <= w_target;
          end
        end
        DRAIN: begin
          if (imem_ack) begin
            r_state <= FETCH;
            r_pc    <= redirect ? w_target : r_redir_pc;
          end else if (redirect) begin
            r_redir_pc <= w_target;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  if_id_slot u_slot (
    .clk        (clk),
    .rstn       (rstn),
    .i_capture  (w_capture),
    .i_instr    (imem_rdata),
    .i_pc       (r_pc),
    .i_consume  (w_consume),
    .i_flush    (redirect),
    .o_valid    (if_valid),
    .o_instr    (if_instr),
    .o_pc       (if_pc),
    .o_pc_plus4 (if_pc_plus4)
  );

  assign if_opcode = if_instr[31:26];

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage for the MIPS datapath: owns the program counter, issues requests to instruction memory, and presents one fetched instruction, with its PC, to decode through a valid/ready slot. `if_opcode` drives the control unit's opcode input directly. Branch and jump outcomes resolved downstream come back as a single redirect, which flushes the slot and any in-flight fetch.

## Interface
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset; bits [1:0] must be 0.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rstn`  in  1  reset, asynchronous, active-low.
- `imem_req`  out  1  fetch request; once high, held high with `imem_addr` stable until the cycle `imem_ack` is high.
- `imem_addr`  out  32  word-aligned fetch address.
- `imem_ack`  in  1  one-cycle response strobe; may be high in the same cycle `imem_req` first rises (zero-wait).
- `imem_rdata`  in  32  instruction word, valid when `imem_ack` is high.
- `redirect`  in  1  taken branch or jump; one-cycle pulse.
- `redirect_pc`  in  32  new PC; bits [1:0] ignored and forced to 0.
- `if_valid`  out  1  slot holds a valid instruction.
- `if_ready`  in  1  decode accepts the slot this cycle.
- `if_instr`  out  32  fetched instruction.
- `if_opcode`  out  6  `if_instr[31:26]`.
- `if_pc`  out  32  address of `if_instr`.
- `if_pc_plus4`  out  32  `if_pc + 4`, modulo 2^32.

## Operation
- Reset values:
  - `pc` = `RESET_PC`, state = IDLE, `if_valid` = 0.
  - `if_instr`, `if_pc` and `if_pc_plus4` = 0.
  - `imem_req` = 0 and `imem_addr` = `RESET_PC`.
- `imem_addr` = `pc` at all times.
- IDLE: `imem_req` = 0; go to FETCH on the next edge.
- FETCH: `imem_req` = `!if_valid | if_ready`. This is combinational, and a request is issued only when the slot is free or is being freed this cycle.
  - req & ack: capture into the slot (`if_valid` <= 1, `if_instr` <= `imem_rdata`, `if_pc` <= `pc`), then `pc` <= `pc` + 4 and stay in FETCH.
  - req & !ack: go to WAIT.
- WAIT: `imem_req` = 1. The slot is guaranteed empty here, because only an ack can fill it.
  - ack: capture into the slot, `pc` += 4, go to FETCH.
- DRAIN: `imem_req` = 1 with the old `imem_addr` until ack. The returned data is discarded. On ack, go to FETCH with `pc` = the latched redirect target.
- Slot handshake: when `if_valid & if_ready` and there is no capture in the same cycle, `if_valid` <= 0.
- Redirect has priority over every other event:
  - The slot is cleared: `if_valid` <= 0 next cycle. Any `if_valid & if_ready` in that same cycle still counts as accepted by decode.
  - FETCH or IDLE, with no outstanding request: `pc` <= `redirect_pc`.
  - FETCH with req & ack, or WAIT with ack: discard the data, `pc` <= `redirect_pc`, go to FETCH.
  - FETCH with req & !ack, or WAIT with !ack: latch the target and go to DRAIN.
  - DRAIN: overwrite the latched target and stay in DRAIN until ack.
- PC wraps: 32'hFFFF_FFFC + 4 = 32'h0000_0000, with no error.
- Asserting `rstn` mid-request drops `imem_req` immediately. Memory must tolerate an abandoned request.

## Timing
- Zero-wait memory with `if_ready` held at 1: one instruction per cycle. `if_valid` rises on the edge after the ack.
- Latency from reset release: `imem_req` is high in the 2nd cycle; `if_valid` is high in the 3rd cycle with zero-wait memory.
- N-cycle memory: `if_valid` rises on the edge after the ack cycle.
- Redirect in cycle t: `imem_addr` = `redirect_pc` from t+1 if no request was outstanding, else from the cycle after the draining ack.
- No combinational path from `imem_rdata` to the `if_*` outputs. `imem_req` depends combinationally on `if_ready` and `if_valid` only.

## Structure
- Shared package `fetch_pkg` holds:
  - the state enum IDLE/FETCH/WAIT/DRAIN;
  - the `INSTR_W`/`ADDR_W` constants (32);
  - the `PC_STEP` constant (4).
- One natural sub-module, `if_id_slot`: a single-entry valid/ready register with capture, consume and flush inputs.
- The PC, FSM and redirect latch stay in `instr_fetch`.

## Test plan
- Reset release, `RESET_PC` = 0, zero-wait memory returning 32'h2001_0005 at address 0 -> `if_valid` in the 3rd cycle; `if_opcode` = 6'b001000; `if_pc` = 0; `if_pc_plus4` = 4.
- Streaming with `if_ready` = 1 and zero-wait memory -> `imem_addr` sequence 0, 4, 8, 12 on consecutive cycles; one instruction accepted per cycle, in order.
- Hold `if_ready` = 0 for 3 cycles with the slot full -> `imem_req` = 0 and the slot contents are stable; when `if_ready` rises, the request resumes at the next PC.
- 3-cycle memory; redirect to 32'h0000_0040 one cycle after the request -> `imem_addr` holds the old address until ack, that data is never presented, and the next request is at 0x40.
- Redirect in the same cycle as a zero-wait ack, `redirect_pc` = 32'h0000_0103 -> the acked data is dropped and the next `imem_addr` = 32'h0000_0100.
- `pc` = 32'hFFFF_FFFC -> `if_pc_plus4` = 0 and the next fetch is at 0; also assert `rstn` low mid-WAIT -> `imem_req` and `if_valid` go to 0 asynchronously.
